// File: rtl/agc_loop_ctrl.sv
// agc_loop_ctrl: AGC loop controller downstream of the power estimator.
// It periodically requests a power measurement (log_start), then waits for
// pwr_est_end/pwr_est_dB. It integrates a scaled error against TARGET_DB into a
// saturating unsigned gain word, and reports lock once the error has stayed
// inside a small window.
//
// Optional build macro: AGC_DEADBAND_EN
//   defined   -> errors with |err| <= DEADBAND produce a zero gain step.
//   undefined -> the gain step is always err >>> STEP_SHIFT, and DEADBAND has
//                no effect on the datapath.
module agc_loop_ctrl #(
  parameter logic [8:0] TARGET_DB  = 9'd200,
  parameter int         GAIN_W     = 10,
  parameter int         MEAS_INTV  = 64,
  parameter int         STEP_SHIFT = 2,
  parameter int         LOCK_THR   = 4,
  parameter int         LOCK_CNT   = 4,
  parameter int         TIMEOUT    = 32,
  parameter int         DEADBAND   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              agc_en,
  input  logic [GAIN_W-1:0] gain_init,
  input  logic [8:0]        pwr_est_dB,
  input  logic              pwr_est_end,
  output logic              log_start,
  output logic [GAIN_W-1:0] agc_gain,
  output logic              agc_gain_vld,
  output logic [9:0]        pwr_err,
  output logic              agc_lock,
  output logic              meas_timeout
);

  // Counter widths are sized to hold their reload values.
  localparam int INTV_W = $clog2(MEAS_INTV + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int LCNT_W = $clog2(LOCK_CNT + 1);

  // The gain/delta sum needs two bits of headroom over the gain word. It also
  // needs to be at least as wide as the sign-extended 10-bit error.
  localparam int SUM_W = (GAIN_W + 2 > 11) ? GAIN_W + 2 : 11;

  localparam logic [INTV_W-1:0]       INTV_RELOAD = INTV_W'(MEAS_INTV - 1);
  localparam logic [TO_W-1:0]         TO_RELOAD   = TO_W'(TIMEOUT - 1);
  localparam logic [LCNT_W-1:0]       LOCK_CNT_V  = LCNT_W'(LOCK_CNT);
  localparam logic [9:0]              LOCK_THR_V  = 10'(LOCK_THR);
  localparam logic signed [SUM_W-1:0] GAIN_MAX_S  = SUM_W'((1 << GAIN_W) - 1);

  // Parameter sanity checks, evaluated at elaboration only.
  if (MEAS_INTV < 2) begin : g_chk_intv
    $error("agc_loop_ctrl: MEAS_INTV must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("agc_loop_ctrl: TIMEOUT must be at least 1");
  end
  if (LOCK_CNT < 1) begin : g_chk_lock
    $error("agc_loop_ctrl: LOCK_CNT must be at least 1");
  end
  if (DEADBAND < 0 || DEADBAND > 511) begin : g_chk_deadband
    $error("agc_loop_ctrl: DEADBAND must lie in 0..511");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MEAS = 2'd2,
    S_UPD  = 2'd3
  } state_t;

  state_t                   state_q,        state_d;
  logic [INTV_W-1:0]        intv_cnt_q,     intv_cnt_d;
  logic [TO_W-1:0]          to_cnt_q,       to_cnt_d;
  logic [LCNT_W-1:0]        lock_cnt_q,     lock_cnt_d;
  logic [GAIN_W-1:0]        agc_gain_q,     agc_gain_d;
  logic signed [9:0]        pwr_err_q,      pwr_err_d;
  logic                     agc_gain_vld_q, agc_gain_vld_d;
  logic                     agc_lock_q,     agc_lock_d;
  logic                     log_start_q,    log_start_d;
  logic                     meas_timeout_q, meas_timeout_d;

  logic signed [9:0]        meas_err;
  logic [9:0]               abs_err;
  logic signed [9:0]        delta;
  logic signed [SUM_W-1:0]  gain_ext;
  logic signed [SUM_W-1:0]  delta_ext;
  logic signed [SUM_W-1:0]  gain_sum;

  // Magnitude of a 10-bit signed error. The error range is -511..511, so the
  // result always fits in 10 bits.
  function automatic logic [9:0] abs10(input logic signed [9:0] v);
    return v[9] ? -v : v;
  endfunction

  // Clamp the signed gain sum into the unsigned gain range instead of wrapping.
  function automatic logic [GAIN_W-1:0] sat_gain(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])
      return '0;
    else if (s > GAIN_MAX_S)
      return '1;
    else
      return s[GAIN_W-1:0];
  endfunction

  // Error datapath: capture error, loop-gain step, and saturating integration.
  always_comb begin
    meas_err  = $signed({1'b0, TARGET_DB}) - $signed({1'b0, pwr_est_dB});
    abs_err   = abs10(pwr_err_q);
    delta     = pwr_err_q >>> STEP_SHIFT;
`ifdef AGC_DEADBAND_EN
    if (abs_err <= 10'(DEADBAND))
      delta = '0;
`endif
    gain_ext  = $signed(SUM_W'(agc_gain_q));
    delta_ext = SUM_W'(delta);
    gain_sum  = gain_ext + delta_ext;
  end

  // Loop FSM: next state, counters, gain/lock update and output pulses.
  always_comb begin
    state_d        = state_q;
    intv_cnt_d     = intv_cnt_q;
    to_cnt_d       = to_cnt_q;
    lock_cnt_d     = lock_cnt_q;
    agc_gain_d     = agc_gain_q;
    pwr_err_d      = pwr_err_q;
    agc_lock_d     = agc_lock_q;
    agc_gain_vld_d = 1'b0;
    log_start_d    = 1'b0;
    meas_timeout_d = 1'b0;

    if (!agc_en) begin
      // Abort from any state: the gain and the last error are held, and loop
      // status is cleared so that a re-enable starts fresh.
      state_d    = S_IDLE;
      intv_cnt_d = '0;
      to_cnt_d   = '0;
      lock_cnt_d = '0;
      agc_lock_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_WAIT;
          agc_gain_d = gain_init;
          intv_cnt_d = INTV_RELOAD;
        end

        S_WAIT: begin
          if (intv_cnt_q == '0) begin
            state_d     = S_MEAS;
            log_start_d = 1'b1;
            to_cnt_d    = TO_RELOAD;
          end else begin
            intv_cnt_d = intv_cnt_q - 1'b1;
          end
        end

        S_MEAS: begin
          // A reply on the expiry cycle still counts, so it is checked first.
          if (pwr_est_end) begin
            pwr_err_d = meas_err;
            state_d   = S_UPD;
          end else if (to_cnt_q == '0) begin
            meas_timeout_d = 1'b1;
            state_d        = S_WAIT;
            intv_cnt_d     = INTV_RELOAD;
          end else begin
            to_cnt_d = to_cnt_q - 1'b1;
          end
        end

        S_UPD: begin
          agc_gain_d     = sat_gain(gain_sum);
          agc_gain_vld_d = 1'b1;
          if (abs_err <= LOCK_THR_V) begin
            lock_cnt_d = (lock_cnt_q == LOCK_CNT_V) ? lock_cnt_q : lock_cnt_q + 1'b1;
            if (lock_cnt_d == LOCK_CNT_V)
              agc_lock_d = 1'b1;
          end else begin
            lock_cnt_d = '0;
            agc_lock_d = 1'b0;
          end
          state_d    = S_WAIT;
          intv_cnt_d = INTV_RELOAD;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      intv_cnt_q     <= '0;
      to_cnt_q       <= '0;
      lock_cnt_q     <= '0;
      agc_gain_q     <= '0;
      pwr_err_q      <= '0;
      agc_lock_q     <= 1'b0;
      agc_gain_vld_q <= 1'b0;
      log_start_q    <= 1'b0;
      meas_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      intv_cnt_q     <= intv_cnt_d;
      to_cnt_q       <= to_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      agc_gain_q     <= agc_gain_d;
      pwr_err_q      <= pwr_err_d;
      agc_lock_q     <= agc_lock_d;
      agc_gain_vld_q <= agc_gain_vld_d;
      log_start_q    <= log_start_d;
      meas_timeout_q <= meas_timeout_d;
    end
  end

  assign log_start    = log_start_q;
  assign agc_gain     = agc_gain_q;
  assign agc_gain_vld = agc_gain_vld_q;
  assign pwr_err      = pwr_err_q;
  assign agc_lock     = agc_lock_q;
  assign meas_timeout = meas_timeout_q;

endmodule

// File: doc/agc_loop_ctrl.md
Name: agc_loop_ctrl

Overview:
AGC loop controller sitting directly downstream of the power estimator. Periodically issues a one-cycle log_start and waits for the estimator's pwr_est_end and pwr_est_dB. Computes the error against a target level, integrates a scaled error into a saturating gain word for the RF/analog gain stage, and reports loop lock.

Parameters:
TARGET_DB, 9'd200, target power code, same units as pwr_est_dB
GAIN_W, 10, gain word width, unsigned
MEAS_INTV, 64, cycles spent in WAIT between measurements (>=2)
STEP_SHIFT, 2, loop gain: delta = err >>> STEP_SHIFT
LOCK_THR, 4, |err| <= LOCK_THR counts as in-window
LOCK_CNT, 4, consecutive in-window updates required for lock
TIMEOUT, 32, max cycles in MEAS awaiting pwr_est_end
DEADBAND, 2, dead zone half-width; used only with AGC_DEADBAND_EN

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
agc_en  in  1  loop enable, level
gain_init  in  GAIN_W  gain loaded when loop starts
pwr_est_dB  in  9  estimated power code, valid when pwr_est_end=1
pwr_est_end  in  1  one-cycle pulse: new estimate available
log_start  out  1  one-cycle measurement request to estimator
agc_gain  out  GAIN_W  current gain word
agc_gain_vld  out  1  one-cycle pulse when agc_gain is (re)written by an update
pwr_err  out  10  signed TARGET_DB - pwr_est_dB of last measurement
agc_lock  out  1  loop locked
meas_timeout  out  1  one-cycle pulse on measurement timeout

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- States: IDLE, WAIT, MEAS, UPD. All outputs registered.
- IDLE: when agc_en=1, go to WAIT, load agc_gain<=gain_init, load the interval counter with MEAS_INTV-1. No agc_gain_vld on load.
- WAIT: decrement counter. At 0, go to MEAS. log_start=1 for exactly the first cycle in MEAS. Load the timeout counter with TIMEOUT-1.
- MEAS: on a clock edge with pwr_est_end=1, register pwr_err = {1'b0,TARGET_DB} - {1'b0,pwr_est_dB} (10-bit signed, range -511..511) and go to UPD. If the timeout counter reaches 0 without pwr_est_end: pulse meas_timeout, leave gain and lock unchanged, go to WAIT, reload the interval.
- UPD (one cycle): delta = pwr_err >>> STEP_SHIFT, arithmetic with floor rounding (-3>>>2 = -1). sum = agc_gain + delta, computed at GAIN_W+2 signed. Clamp to [0, 2^GAIN_W-1]. agc_gain<=clamped sum and agc_gain_vld=1 on the same edge. Then go to WAIT and reload the interval.
- Latency: pwr_est_end sampled at edge k, so pwr_err is valid after edge k. agc_gain and agc_gain_vld change after edge k+1. One log_start per MEAS_INTV+measurement+1 cycles.
- Positive error (weak signal) raises gain. Negative error lowers gain.
- Lock: in UPD, if |pwr_err| <= LOCK_THR, increment lock_cnt (saturating at LOCK_CNT). Otherwise lock_cnt<=0 and agc_lock<=0. agc_lock<=1 on the update where lock_cnt reaches LOCK_CNT.
- pwr_est_end outside MEAS is ignored (no state or output change).
- agc_en=0 in any state: next edge goes to IDLE, clears agc_lock, lock_cnt and counters, and holds agc_gain and pwr_err. Any log_start already issued is not retracted. A late pwr_est_end is ignored.
- agc_en re-assert restarts from IDLE with a gain_init reload.
- Simultaneous pwr_est_end and timeout expiry in MEAS: pwr_est_end wins, no meas_timeout.

Optional Feature:
AGC_DEADBAND_EN
- Defined: in UPD, if |pwr_err| <= DEADBAND, delta is forced to 0. agc_gain is held, but agc_gain_vld still pulses and lock logic runs normally.
- Undefined: delta is always pwr_err >>> STEP_SHIFT. The DEADBAND parameter is unused.

Test Plan:
1. Reset, then agc_en=1 with gain_init=512 -> agc_gain=512 one edge later, no vld. log_start pulses after MEAS_INTV=64 cycles. Enable held low -> log_start never pulses.
2. Reply pwr_est_dB=180 -> pwr_err=+20, agc_gain=517 with vld. Reply 300 -> pwr_err=-100, agc_gain=492. Verify the 2-edge latency from pwr_est_end to agc_gain.
3. Saturation: gain=1020 with pwr 100 -> 1023 (not wrap). Gain=3 with pwr 400 (err -200, delta -50) -> 0. Odd negative err -3 -> delta -1.
4. Lock: replies 199, 201, 198, 202 -> agc_lock rises on the 4th update. Next reply 220 -> agc_lock=0 on that update.
5. Timeout and abort: no pwr_est_end for 32 cycles after log_start -> meas_timeout pulse, gain unchanged, next log_start after a full interval. Drop agc_en mid-MEAS, then pulse pwr_est_end -> no update, state IDLE.
6. With AGC_DEADBAND_EN: gain=512, reply 199 (err +1) -> vld pulses, gain stays 512. Without the macro -> gain 512 (delta 0 by shift). Reply 196 (err +4) -> 513 in both builds.
